sdram_usb_drain: RTL and testbench

//  Read-side consumer of the SDRAM controller top. Drains a block of captured ADC words from the SDRAM

---
 rtl/sdram_usb_drain.sv | 197 +++++++++++++++++++
 tb/tb_sdram_usb_drain.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_usb_drain.sv
// Drains captured ADC words from the SDRAM read FIFO into the 16-bit USB slave FIFO, with short-packet flush.
// Optional internal counter data source when USB_DRAIN_TESTPAT_EN is defined (adds test_mode input).
`timescale 1ns/1ps
module sdram_usb_drain #(
  parameter int         PKT_WORDS = 256,
  parameter int         LOAD_CYC  = 4,
  parameter logic [1:0] EP_ADDR   = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] cfg_total,
  output logic        busy,
  output logic        done,
  output logic        rd_load,
  output logic        sdram_read_valid,
  output logic        rd_en,
  input  logic [15:0] rd_data,
  input  logic        rdf_empty,
  input  logic        usb_full_n,
  output logic        usb_slwr_n,
  output logic        usb_pktend_n,
  output logic [15:0] usb_fd,
  output logic [1:0]  usb_fifoadr
`ifdef USB_DRAIN_TESTPAT_EN
  ,
  input  logic        test_mode
`endif
);

  localparam int PW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int LW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t         state;
  logic [LW-1:0]  load_cnt;
  logic [23:0]    total;
  logic [23:0]    issued;
  logic [23:0]    written;
  logic [PW-1:0]  pkt_cnt;
  logic [15:0]    fifo_mem [2];
  logic           wp;
  logic           rp;
  logic [1:0]     occ;
  logic           inflight;

  logic           wr_fire;
  logic           space_ok;
  logic           last_wr;
  logic           pkt_wrap;
  logic           issue;
  logic           push;
  logic [15:0]    push_data;

  assign wr_fire  = (state == S_RUN) && (occ != 2'd0) && usb_full_n;
  // a word being written this cycle frees its slot for the read issued now
  assign space_ok = ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, wr_fire});
  assign last_wr  = wr_fire && ((written + 24'd1) == total);
  assign pkt_wrap = (pkt_cnt == PW'(PKT_WORDS - 1));

`ifdef USB_DRAIN_TESTPAT_EN
  logic        tm;
  logic [15:0] tp_cnt;
  logic        tp_load;

  assign rd_en     = (state == S_RUN) && !tm && !rdf_empty && (issued < total) && space_ok;
  assign tp_load   = (state == S_RUN) && tm && (issued < total) && space_ok;
  assign issue     = rd_en | tp_load;
  assign push      = tm ? tp_load : inflight;
  assign push_data = tm ? tp_cnt : rd_data;
`else
  assign rd_en     = (state == S_RUN) && !rdf_empty && (issued < total) && space_ok;
  assign issue     = rd_en;
  assign push      = inflight;
  assign push_data = rd_data;
`endif

  assign usb_slwr_n   = ~wr_fire;
  assign usb_pktend_n = ~((state == S_FLUSH) && usb_full_n);
  assign usb_fd       = fifo_mem[rp];
  assign usb_fifoadr  = EP_ADDR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      rd_load          <= 1'b0;
      sdram_read_valid <= 1'b0;
      load_cnt         <= '0;
      total            <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD;
            busy     <= 1'b1;
            rd_load  <= 1'b1;
            total    <= cfg_total;
            load_cnt <= LW'(LOAD_CYC - 1);
          end
        end
        S_LOAD: begin
          if (load_cnt == '0) begin
            rd_load <= 1'b0;
            if (total == 24'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state            <= S_RUN;
              sdram_read_valid <= 1'b1;
            end
          end else begin
            load_cnt <= load_cnt - LW'(1);
          end
        end
        S_RUN: begin
          if (last_wr) begin
            if (pkt_wrap) begin
              state            <= S_DONE;
              done             <= 1'b1;
              sdram_read_valid <= 1'b0;
            end else begin
              state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (usb_full_n) begin
            state            <= S_DONE;
            done             <= 1'b1;
            sdram_read_valid <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued      <= '0;
      written     <= '0;
      pkt_cnt     <= '0;
      inflight    <= 1'b0;
      wp          <= 1'b0;
      rp          <= 1'b0;
      occ         <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
`ifdef USB_DRAIN_TESTPAT_EN
      tm          <= 1'b0;
      tp_cnt      <= '0;
`endif
    end else begin
      inflight <= rd_en;
      if ((state == S_IDLE) && start) begin
        issued  <= '0;
        written <= '0;
        pkt_cnt <= '0;
`ifdef USB_DRAIN_TESTPAT_EN
        tm      <= test_mode;
        tp_cnt  <= '0;
`endif
      end else begin
        if (issue)
          issued <= issued + 24'd1;
        if (wr_fire) begin
          written <= written + 24'd1;
          pkt_cnt <= pkt_wrap ? '0 : pkt_cnt + PW'(1);
        end
`ifdef USB_DRAIN_TESTPAT_EN
        if (tp_load)
          tp_cnt <= tp_cnt + 16'd1;
`endif
      end
      if (push) begin
        fifo_mem[wp] <= push_data;
        wp           <= ~wp;
      end
      if (wr_fire)
        rp <= ~rp;
      case ({push, wr_fire})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_usb_drain.sv
// Scoreboard bench for sdram_usb_drain: models the SDRAM read FIFO and checks USB writes, pktend and done timing.
`timescale 1ns/1ps
module tb_sdram_usb_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] cfg_total;
  logic        busy, done, rd_load, sdram_read_valid, rd_en;
  logic [15:0] rd_data;
  logic        rdf_empty;
  logic        usb_full_n;
  logic        usb_slwr_n, usb_pktend_n;
  logic [15:0] usb_fd;
  logic [1:0]  usb_fifoadr;
`ifdef USB_DRAIN_TESTPAT_EN
  logic        test_mode = 1'b0;
`endif

  always #5 clk = ~clk;

  sdram_usb_drain dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .cfg_total        (cfg_total),
    .busy             (busy),
    .done             (done),
    .rd_load          (rd_load),
    .sdram_read_valid (sdram_read_valid),
    .rd_en            (rd_en),
    .rd_data          (rd_data),
    .rdf_empty        (rdf_empty),
    .usb_full_n       (usb_full_n),
    .usb_slwr_n       (usb_slwr_n),
    .usb_pktend_n     (usb_pktend_n),
    .usb_fd           (usb_fd),
    .usb_fifoadr      (usb_fifoadr)
`ifdef USB_DRAIN_TESTPAT_EN
    ,
    .test_mode        (test_mode)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input int i);
    return 16'(i * 40503 + 4660);
  endfunction

  int          cyc = 0;
  int          n_rd, n_wr, n_pkt, n_done, n_load;
  int          first_wr, last_wr, pkt_cyc, done_cyc, full_viol, max_out;
  logic        pend = 1'b0;
  logic [15:0] pend_val;
  logic [15:0] exp_q [$];
  bit          rand_empty;
  int          full_at;
  int          full_left;
  bit          full_used;

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) begin
        pend_val = word_of(n_rd);
        pend     = 1'b1;
        exp_q.push_back(pend_val);
        n_rd++;
      end
      if (!usb_slwr_n) begin
        if (n_wr == 0) first_wr = cyc;
        last_wr = cyc;
        n_wr++;
        if (!usb_full_n) full_viol++;
        if (exp_q.size() == 0) chk("wr_extra", 32'd1, 32'd0);
        else chk("wr_data", {16'd0, usb_fd}, {16'd0, exp_q.pop_front()});
      end
      if (!usb_pktend_n) begin
        n_pkt++;
        pkt_cyc = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (rd_load) n_load++;
      if (n_rd - n_wr > max_out) max_out = n_rd - n_wr;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    if (pend) begin
      rd_data = pend_val;
      pend    = 1'b0;
    end
    rdf_empty = rand_empty ? ($urandom_range(0, 2) == 0) : 1'b0;
    if (full_at >= 0 && n_wr == full_at && !full_used) begin
      full_used = 1'b1;
      full_left = 5;
    end
    if (full_left > 0) begin
      usb_full_n = 1'b0;
      full_left--;
    end else begin
      usb_full_n = 1'b1;
    end
  endtask

  task automatic clear_stats();
    n_rd = 0; n_wr = 0; n_pkt = 0; n_done = 0; n_load = 0;
    first_wr = 0; last_wr = 0; pkt_cyc = 0; done_cyc = 0;
    full_viol = 0; max_out = 0;
    exp_q.delete();
    pend = 1'b0;
    full_used = 1'b0;
    full_left = 0;
  endtask

  task automatic wait_done(input string tag);
    int b;
    b = 0;
    while (n_done == 0 && b < 20000) begin
      step();
      b++;
    end
    chk({tag, "_timeout"}, {31'd0, n_done > 0}, 32'd1);
    step();
    step();
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input string tag, input int total, input int f_at, input bit rnd);
    clear_stats();
    rand_empty = rnd;
    full_at    = f_at;
    cfg_total  = 24'(total);
    start      = 1'b1;
    step();
    wait_done(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},   {31'd0, busy},             32'd0);
    chk({tag, "_done"},   {31'd0, done},             32'd0);
    chk({tag, "_load"},   {31'd0, rd_load},          32'd0);
    chk({tag, "_srv"},    {31'd0, sdram_read_valid}, 32'd0);
    chk({tag, "_rden"},   {31'd0, rd_en},            32'd0);
    chk({tag, "_slwr"},   {31'd0, usb_slwr_n},       32'd1);
    chk({tag, "_pktend"}, {31'd0, usb_pktend_n},     32'd1);
    chk({tag, "_fd"},     {16'd0, usb_fd},           32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_total = '0; rd_data = '0;
    rdf_empty = 1'b0; usb_full_n = 1'b1; rand_empty = 1'b0; full_at = -1;
    clear_stats();
    repeat (3) step();
    check_reset_outputs("rst");
    chk("fifoadr", {30'd0, usb_fifoadr}, 32'd2);
    rst = 1'b0;
    step();

    // full packets only: back-to-back writes, no pktend, done right after last write
    run("t1", 512, -1, 1'b0);
    chk("t1_rd",      n_rd, 512);
    chk("t1_wr",      n_wr, 512);
    chk("t1_burst",   last_wr - first_wr, 511);
    chk("t1_pktend",  n_pkt, 0);
    chk("t1_done_at", done_cyc - last_wr, 1);
    chk("t1_done_n",  n_done, 1);
    chk("t1_load",    n_load, 4);

    // short final packet of 44 words
    run("t2", 300, -1, 1'b0);
    chk("t2_wr",      n_wr, 300);
    chk("t2_pktend",  n_pkt, 1);
    chk("t2_pkt_at",  pkt_cyc - last_wr, 1);
    chk("t2_done_at", done_cyc - pkt_cyc, 1);
    chk("t2_left",    exp_q.size(), 0);

    // USB full for 5 cycles at word 100
    run("t3", 300, 100, 1'b0);
    chk("t3_wr",        n_wr, 300);
    chk("t3_rd",        n_rd, 300);
    chk("t3_full_wr",   full_viol, 0);
    chk("t3_full_seen", {31'd0, full_used}, 32'd1);
    chk("t3_pktend",    n_pkt, 1);
    chk("t3_occ",       {31'd0, max_out <= 3}, 32'd1);

    // random read FIFO starvation
    run("t4", 1000, -1, 1'b1);
    chk("t4_rd",     n_rd, 1000);
    chk("t4_wr",     n_wr, 1000);
    chk("t4_occ",    {31'd0, max_out <= 3}, 32'd1);
    chk("t4_pktend", n_pkt, 1);
    chk("t4_left",   exp_q.size(), 0);
    rand_empty = 1'b0;

    // zero-length transfer, plus a start pulse while busy that must be ignored
    clear_stats();
    full_at   = -1;
    cfg_total = 24'd0;
    start     = 1'b1;
    step();
    chk("t5_busy", {31'd0, busy}, 32'd1);
    step();
    cfg_total = 24'd7;
    start     = 1'b1;
    step();
    wait_done("t5");
    repeat (10) step();
    chk("t5_load",   n_load, 4);
    chk("t5_rd",     n_rd, 0);
    chk("t5_wr",     n_wr, 0);
    chk("t5_pktend", n_pkt, 0);
    chk("t5_done_n", n_done, 1);
    chk("t5_busy_after", {31'd0, busy}, 32'd0);

    // reset in the middle of a transfer
    begin
      int b;
      clear_stats();
      cfg_total = 24'd300;
      start     = 1'b1;
      step();
      b = 0;
      while (n_wr < 50 && b < 2000) begin
        step();
        b++;
      end
      chk("t6_reach50", {31'd0, n_wr >= 50}, 32'd1);
      rst = 1'b1;
      step();
      check_reset_outputs("t6_rst");
      rst = 1'b0;
      repeat (10) step();
      chk("t6_pktend", n_pkt, 0);
      chk("t6_done",   n_done, 0);
    end
    run("t6b", 20, -1, 1'b0);
    chk("t6b_wr",     n_wr, 20);
    chk("t6b_pktend", n_pkt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
